// File: rtl/buf_seq_pkg.sv
// buf_seq_pkg: FSM states, buffer mode encodings and default sizing macros for buffer_sequencer.
`ifndef N_BUF
`define N_BUF 4
`endif
`ifndef ADDR_RAM
`define ADDR_RAM 4
`endif
`ifndef WID_PE_BITS
`define WID_PE_BITS 8
`endif
package buf_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, DONE} state_t;
  localparam logic MODE_SERIAL = 1'b0;
  localparam logic MODE_PARALLEL = 1'b1;
endpackage

// File: rtl/buf_seq_addr_gen.sv
// buf_seq_addr_gen: bank/address counters, bank-fastest in bank mode, address-only otherwise.
module buf_seq_addr_gen #(
  parameter int N_BUF = 4,
  parameter int ADDR_RAM = 4,
  localparam int BW = N_BUF > 1 ? $clog2(N_BUF) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                bank_mode,
  input  logic [ADDR_RAM-1:0] len,
  output logic [BW-1:0]       bank,
  output logic [ADDR_RAM-1:0] addr,
  output logic                last
);
  logic bank_wrap;
  assign bank_wrap = !bank_mode || bank == BW'(N_BUF - 1);
  assign last = bank_wrap && addr == len - ADDR_RAM'(1);
  // wrapping to zero on the terminal step leaves the counters clean for the next phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank <= '0;
      addr <= '0;
    end else if (inc) begin
      bank <= bank_wrap ? '0 : bank + BW'(1);
      addr <= last ? '0 : bank_wrap ? addr + ADDR_RAM'(1) : addr;
    end
  end
endmodule

// File: rtl/buffer_sequencer.sv
// buffer_sequencer: serial bank load then parallel row read job sequencer.
// Define BUF_SEQ_STALL_EN to add the rd_stall input that pauses the READ phase.
module buffer_sequencer
  import buf_seq_pkg::*;
#(
  parameter int N_BUF = `N_BUF,
  parameter int ADDR_RAM = `ADDR_RAM,
  parameter int WID_PE_BITS = `WID_PE_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_RAM-1:0]       load_len,
  input  logic [ADDR_RAM-1:0]       read_len,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WID_PE_BITS-1:0]    s_data,
`ifdef BUF_SEQ_STALL_EN
  input  logic                      rd_stall,
`endif
  output logic                      mode,
  output logic [N_BUF-1:0]          m0_w_en,
  output logic [ADDR_RAM-1:0]       m0_w_addr,
  output logic [WID_PE_BITS-1:0]    m0_w_data,
  output logic [N_BUF-1:0]          m1_r_en,
  output logic [N_BUF*ADDR_RAM-1:0] m1_r_addr,
  output logic                      rd_valid,
  output logic                      busy,
  output logic                      done
);
  localparam int BW = N_BUF > 1 ? $clog2(N_BUF) : 1;
  state_t state, next;
  logic [ADDR_RAM-1:0] load_len_q, read_len_q, addr;
  logic [BW-1:0] bank;
  logic stall, beat, issue, last;
`ifdef BUF_SEQ_STALL_EN
  assign stall = rd_stall;
`else
  assign stall = 1'b0;
`endif
  assign beat = state == LOAD && s_valid;
  assign issue = state == READ && !stall;
  buf_seq_addr_gen #(.N_BUF(N_BUF), .ADDR_RAM(ADDR_RAM)) u_addr_gen (
    .clk(clk),
    .rst(rst),
    .inc(beat || issue),
    .bank_mode(state == LOAD),
    .len(state == LOAD ? load_len_q : read_len_q),
    .bank(bank),
    .addr(addr),
    .last(last)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      load_len_q <= '0;
      read_len_q <= '0;
      rd_valid <= 1'b0;
    end else begin
      state <= next;
      rd_valid <= issue;
      if (state == IDLE && start) begin
        load_len_q <= load_len;
        read_len_q <= read_len;
      end
    end
  end
  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (start) next = load_len != '0 ? LOAD : read_len != '0 ? READ : DONE;
      LOAD: if (beat && last) next = read_len_q != '0 ? READ : DONE;
      READ: if (issue && last) next = DRAIN;
      DRAIN: next = DONE;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  assign mode = state == READ || state == DRAIN ? MODE_PARALLEL : MODE_SERIAL;
  assign s_ready = state == LOAD;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign m0_w_en = beat ? N_BUF'(1) << bank : '0;
  assign m0_w_addr = addr;
  assign m0_w_data = rst ? '0 : s_data;
  assign m1_r_en = issue ? '1 : '0;
  assign m1_r_addr = {N_BUF{addr}};
endmodule

// File: tb/tb_buffer_sequencer.sv
// tb_buffer_sequencer: randomized jobs checked against a phase-level reference model.
module tb_buffer_sequencer;
  import buf_seq_pkg::*;
  localparam int N = `N_BUF;
  localparam int A = `ADDR_RAM;
  localparam int W = `WID_PE_BITS;
  logic clk = 0, rst = 1, start = 0, s_valid = 0;
  logic [A-1:0] load_len = '0, read_len = '0;
  logic [W-1:0] s_data = '0;
  logic s_ready, mode, rd_valid, busy, done;
  logic [N-1:0] m0_w_en, m1_r_en;
  logic [A-1:0] m0_w_addr;
  logic [W-1:0] m0_w_data;
  logic [N*A-1:0] m1_r_addr;
  int tests = 0, fails = 0;
`ifdef BUF_SEQ_STALL_EN
  logic rd_stall = 0;
`endif
  always #5 clk = ~clk;
  buffer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len), .read_len(read_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef BUF_SEQ_STALL_EN
    .rd_stall(rd_stall),
`endif
    .mode(mode), .m0_w_en(m0_w_en), .m0_w_addr(m0_w_addr), .m0_w_data(m0_w_data),
    .m1_r_en(m1_r_en), .m1_r_addr(m1_r_addr), .rd_valid(rd_valid), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_rows(input int r);
    for (int i = 0; i < N; i++) check("r_addr", 64'(m1_r_addr[i*A +: A]), 64'(r));
  endtask
  // one whole job: expected writes are beat k -> bank k%N, address k/N; reads are rows 0..rl-1
  task automatic job(input int ll, input int rl, input int vprob, input int stall_prob, input bit poke);
    int k, r, cyc;
    bit prev_issue, st;
    logic [N-1:0] oh;
    @(negedge clk);
    start = 1; load_len = A'(ll); read_len = A'(rl);
    #1 check("idle_busy", 64'(busy), 0);
    @(negedge clk);
    start = 0; load_len = A'($urandom); read_len = A'($urandom);
    k = 0; cyc = 0;
    while (k < ll * N && cyc < 4000) begin
      s_valid = $urandom_range(0, 99) < vprob;
      s_data = W'($urandom);
      oh = s_valid ? N'(1) << (k % N) : '0;
      #1;
      check("ld_ready", 64'(s_ready), 1);
      check("ld_mode", 64'(mode), 64'(MODE_SERIAL));
      check("ld_w_en", 64'(m0_w_en), 64'(oh));
      check("ld_r_en", 64'(m1_r_en), 0);
      if (s_valid) begin
        check("ld_w_addr", 64'(m0_w_addr), 64'(k / N));
        check("ld_w_data", 64'(m0_w_data), 64'(s_data));
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    if (k < ll * N) check("ld_timeout", 64'(k), 64'(ll * N));
    s_valid = 0;
    r = 0; cyc = 0; prev_issue = 0;
    while (r < rl && cyc < 4000) begin
      st = $urandom_range(0, 99) < stall_prob;
`ifdef BUF_SEQ_STALL_EN
      rd_stall = st;
`else
      st = 0;
`endif
      start = poke && cyc == 1;
      s_valid = 1;
      #1;
      check("rd_mode", 64'(mode), 64'(MODE_PARALLEL));
      check("rd_r_en", 64'(m1_r_en), st ? 0 : 64'({N{1'b1}}));
      check("rd_w_en", 64'(m0_w_en), 0);
      check("rd_ready", 64'(s_ready), 0);
      check("rd_valid", 64'(rd_valid), 64'(prev_issue));
      check_rows(r);
      prev_issue = !st;
      if (!st) r++;
      cyc++;
      @(negedge clk);
    end
    if (r < rl) check("rd_timeout", 64'(r), 64'(rl));
    start = 0; s_valid = 0;
`ifdef BUF_SEQ_STALL_EN
    rd_stall = 0;
`endif
    if (rl != 0) begin
      #1;
      check("dr_r_en", 64'(m1_r_en), 0);
      check("dr_valid", 64'(rd_valid), 1);
      check("dr_mode", 64'(mode), 64'(MODE_PARALLEL));
      check("dr_done", 64'(done), 0);
      @(negedge clk);
    end
    #1;
    check("done", 64'(done), 1);
    check("done_busy", 64'(busy), 1);
    check("done_valid", 64'(rd_valid), 0);
    @(negedge clk);
    #1;
    check("post_done", 64'(done), 0);
    check("post_busy", 64'(busy), 0);
    @(negedge clk);
    #1 check("idle_hold", 64'(busy), 0);
  endtask
  initial begin
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_mode", 64'(mode), 0);
    check("rst_ready", 64'(s_ready), 0);
    check("rst_w_en", 64'(m0_w_en), 0);
    check("rst_r_en", 64'(m1_r_en), 0);
    check("rst_r_addr", 64'(m1_r_addr), 0);
    check("rst_w_addr", 64'(m0_w_addr), 0);
    check("rst_w_data", 64'(m0_w_data), 0);
    check("rst_valid", 64'(rd_valid), 0);
    check("rst_done", 64'(done), 0);
    @(negedge clk);
    rst = 0;
    job(2, 0, 100, 0, 0);
    job(0, 3, 100, 0, 0);
    job(1, 0, 50, 0, 0);
    job(2, 3, 60, 0, 1);
    job(0, 0, 100, 0, 0);
    job((1 << A) - 1, (1 << A) - 1, 80, 0, 0);
    for (int j = 0; j < 6; j++) job($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(30, 100), 30, j % 2);
    // abort on the third beat of a load
    @(negedge clk);
    start = 1; load_len = 2; read_len = 1;
    @(negedge clk);
    start = 0; s_valid = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    check("abort_w_en", 64'(m0_w_en), 0);
    check("abort_busy", 64'(busy), 0);
    check("abort_ready", 64'(s_ready), 0);
    @(negedge clk);
    rst = 0; s_valid = 0;
    job(1, 2, 70, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/buffer_sequencer.md
BUFFER_SEQUENCER -- requirements
Module: buffer_sequencer

Interface
REQ-001 Param N_BUF, default `N_BUF, number of memory banks.
REQ-002 Param ADDR_RAM, default `ADDR_RAM, bank address width.
REQ-003 Param WID_PE_BITS, default `WID_PE_BITS, bank word width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle job-start pulse.
REQ-007 load_len  input  ADDR_RAM  words to load per bank; sampled on accepted start.
REQ-008 read_len  input  ADDR_RAM  parallel read rows; sampled on accepted start.
REQ-009 s_valid / s_ready / s_data  in / out / in  1 / 1 / WID_PE_BITS  serial load stream.
REQ-010 mode  output  1  buffer mode: 0 = serial, 1 = parallel.
REQ-011 m0_w_en / m0_w_addr / m0_w_data  output  N_BUF / ADDR_RAM / WID_PE_BITS  serial write port.
REQ-012 m1_r_en / m1_r_addr  output  N_BUF / N_BUF*ADDR_RAM  parallel read port; bank i address at slice i.
REQ-013 rd_valid  output  1  buffer parallel read data valid this cycle.
REQ-014 busy / done  output  1 / 1  job in progress / one-cycle completion pulse.

Function
REQ-015 FSM states: IDLE, LOAD, READ, DRAIN, DONE.
REQ-016 IDLE: start=1 latches load_len and read_len; next state is LOAD, else READ if load_len=0, else DONE if read_len=0.
REQ-017 start is ignored outside IDLE.
REQ-018 LOAD: mode=0, s_ready=1; each s_valid beat writes s_data to bank b at address a.
REQ-019 m0_w_en is one-hot at bit b only on an accepted beat, else 0; m0_w_data equals s_data combinationally.
REQ-020 Bank counter b steps 0..N_BUF-1 per beat, then wraps to 0 and increments a (round-robin, bank-fastest).
REQ-021 LOAD exits after load_len*N_BUF beats, on the beat writing a=load_len-1, b=N_BUF-1; next state READ, or DONE if read_len=0.
REQ-022 A beat with s_valid=0 holds b and a; no write occurs.
REQ-023 READ: mode=1, m1_r_en all ones, every bank address = row r; r steps 0..read_len-1, one row per cycle.
REQ-024 READ exits after row read_len-1 is issued; next state is DRAIN.
REQ-025 rd_valid is asserted exactly one cycle after each issued row (bank read latency 1); DRAIN supplies the last rd_valid.
REQ-026 DRAIN: mode=1, m1_r_en=0; next state is DONE.
REQ-027 DONE: done=1 for one cycle; next state is IDLE.
REQ-028 busy=1 in every state except IDLE.
REQ-029 Outside LOAD: s_ready=0 and m0_w_en=0. Outside READ: m1_r_en=0.
REQ-030 Counters are ADDR_RAM bits wide; load_len or read_len of 2^ADDR_RAM-1 covers every address but the last, without overflow.

Reset
REQ-031 rst asserted: state=IDLE immediately; all counters=0.
REQ-032 rst asserted: mode, s_ready, m0_w_en, m1_r_en, rd_valid, busy and done = 0; address and data outputs = 0.
REQ-033 rst mid-job aborts the job with no further writes; a partial bank load stays in memory, undefined.

Configuration
REQ-034 Macro BUF_SEQ_STALL_EN defined: input rd_stall (1 bit) is added.
REQ-035 With the macro, rd_stall=1 in READ freezes r, forces m1_r_en=0 and suppresses the rd_valid for that slot.
REQ-036 Without the macro, the port is absent and READ never pauses.

Structure
REQ-037 Package buf_seq_pkg holds the FSM state enum and the mode encoding constants MODE_SERIAL=0 and MODE_PARALLEL=1.
REQ-038 One sub-module, buf_seq_addr_gen, holds the bank/address counters with wrap and terminal-count flags.

Verification
REQ-039 N_BUF=4, load_len=2, read_len=0, 8 beats of data 1..8 -> writes (b0,a0)=1 ... (b3,a0)=4, (b0,a1)=5 ... (b3,a1)=8; done 1 cycle after the 8th beat.
REQ-040 load_len=0, read_len=3 -> m1_r_en=1111 for rows 0,1,2 on consecutive cycles; rd_valid high for 3 cycles, each delayed 1 cycle; then done.
REQ-041 s_valid toggled 1,0,1 during LOAD -> only 2 writes, to b0 then b1, both a0.
REQ-042 start pulsed during READ -> ignored; load_len/read_len unchanged; one done pulse total.
REQ-043 rst asserted on the 3rd LOAD beat -> m0_w_en=0 and busy=0 in the same cycle; next start runs a clean job.
REQ-044 With BUF_SEQ_STALL_EN, rd_stall high on row 1 for 2 cycles -> row 1 is held and rd_valid shows 2 gaps; 3 rows still delivered.
